// File: rtl/time_display_pkg.sv
// Shared types, constants and the 7-segment encoder for the time display.
package time_display_pkg;

   localparam int unsigned SEC_W   = 6;
   localparam int unsigned MIN_W   = 6;
   localparam int unsigned HR_W    = 5;
   localparam int unsigned FIELD_W = 6;   // common converter width (hr zero-extended)
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned SHIFT_N = 6;   // one shift per binary input bit
   localparam int unsigned CNT_W   = 26;  // holds BLINK_DIV-1 up to 2^26-2

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

   // Time-of-day fields as presented by the counter, hr in the MSBs
   typedef struct packed {
      logic [HR_W-1:0]  hr;
      logic [MIN_W-1:0] min;
      logic [SEC_W-1:0] sec;
   } tod_t;

   // BCD digit to active-low segments (bit0=a .. bit6=g); non-decimal codes blank
   function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/time_display_bin2bcd6_step.sv
// Sequential 6-bit binary to two-digit BCD converter (shift-and-add-3).
// Ports: clk, rst (sync, active-high), load (capture din, clear BCD),
//        shift (one adjust+shift step), din[5:0], tens/ones BCD digits.
module bin2bcd6_step
   import time_display_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               shift,
   input  logic [FIELD_W-1:0] din,
   output logic [3:0]         tens,
   output logic [3:0]         ones
);

   logic [FIELD_W-1:0] bin;
   logic [7:0]         bcd;
   logic [7:0]         adj;

   // Add 3 to any nibble >= 5 ahead of the shift
   always_comb begin
      adj = bcd;
      if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin <= '0;
         bcd <= '0;
      end else if (load) begin
         bin <= din;
         bcd <= '0;
      end else if (shift) begin
         {bcd, bin} <= {adj[6:0], bin, 1'b0};
      end
   end

   assign tens = bcd[7:4];
   assign ones = bcd[3:0];

endmodule

// File: rtl/time_display.sv
// HH:MM:SS display back end: samples async time fields, converts each to BCD
// once the inputs are stable and changed, and drives six active-low digits.
// Ports: clk, rst (sync, active-high), sec/min/hr binary fields, set_mode
//        (async, blinks HH/MM), HEX0..HEX5 segments, update_done commit pulse.
module time_display
   import time_display_pkg::*;
#(
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEC_W-1:0] sec,
   input  logic [MIN_W-1:0] min,
   input  logic [HR_W-1:0]  hr,
   input  logic             set_mode,
   output logic [SEG_W-1:0] HEX0,
   output logic [SEG_W-1:0] HEX1,
   output logic [SEG_W-1:0] HEX2,
   output logic [SEG_W-1:0] HEX3,
   output logic [SEG_W-1:0] HEX4,
   output logic [SEG_W-1:0] HEX5,
   output logic             update_done
);

   state_t           state;
   tod_t             cur;
   tod_t             smp;
   tod_t             committed;
   tod_t             ld;
   logic [2:0]       bit_cnt;
   logic [SEG_W-1:0] hex_r [6];
   logic [3:0]       s_tens, s_ones, m_tens, m_ones, h_tens, h_ones;
   logic             conv_load, conv_shift;

   logic             sm_meta, set_mode_s;
   logic [CNT_W-1:0] blink_cnt;
   logic             phase;
   logic             blank;

   assign cur        = {hr, min, sec};
   assign conv_load  = (state == LOAD);
   assign conv_shift = (state == SHIFT);

   bin2bcd6_step u_sec (.clk(clk), .rst(rst), .load(conv_load), .shift(conv_shift),
                        .din(smp.sec), .tens(s_tens), .ones(s_ones));
   bin2bcd6_step u_min (.clk(clk), .rst(rst), .load(conv_load), .shift(conv_shift),
                        .din(smp.min), .tens(m_tens), .ones(m_ones));
   bin2bcd6_step u_hr  (.clk(clk), .rst(rst), .load(conv_load), .shift(conv_shift),
                        .din(FIELD_W'(smp.hr)), .tens(h_tens), .ones(h_ones));

   // Sampling, conversion sequencing and digit commit
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         smp         <= '0;
         committed   <= '1;   // 31:63:63 never matches a zero sample, forcing a first conversion
         ld          <= '0;
         bit_cnt     <= '0;
         update_done <= 1'b0;
         for (int i = 0; i < 6; i++) hex_r[i] <= SEG_BLANK;
      end else begin
         smp         <= cur;
         update_done <= 1'b0;
         case (state)
            IDLE: begin
               // Two matching samples guard against catching a field mid-change
               if ((cur == smp) && (smp != committed)) state <= LOAD;
            end
            LOAD: begin
               ld      <= smp;
               bit_cnt <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'(SHIFT_N - 1)) state <= COMMIT;
            end
            COMMIT: begin
               hex_r[0]    <= seg7(s_ones);
               hex_r[1]    <= seg7(s_tens);
               hex_r[2]    <= seg7(m_ones);
               hex_r[3]    <= seg7(m_tens);
               hex_r[4]    <= seg7(h_ones);
               hex_r[5]    <= seg7(h_tens);
               committed   <= ld;
               update_done <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // set_mode synchroniser and blink phase generator
   always_ff @(posedge clk) begin
      if (rst) begin
         sm_meta    <= 1'b0;
         set_mode_s <= 1'b0;
         blink_cnt  <= '0;
         phase      <= 1'b0;
      end else begin
         sm_meta    <= set_mode;
         set_mode_s <= sm_meta;
         if (!set_mode_s) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
         end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
         end
      end
   end

   // Gating with set_mode_s restores digits the same cycle set mode drops
   assign blank = phase & set_mode_s;

   assign HEX0 = hex_r[0];
   assign HEX1 = hex_r[1];
   assign HEX2 = blank ? SEG_BLANK : hex_r[2];
   assign HEX3 = blank ? SEG_BLANK : hex_r[3];
   assign HEX4 = blank ? SEG_BLANK : hex_r[4];
   assign HEX5 = blank ? SEG_BLANK : hex_r[5];

endmodule

// File: doc/time_display.md
Name: time_display

Overview:
- Display back end for the time-of-day counter. Consumes the binary sec/min/hr fields and drives six active-low 7-segment digits, laid out as HH:MM:SS on HEX5..HEX0.
- Each field is converted binary-to-BCD sequentially (shift-and-add-3, one bit per cycle), with all three fields converted in parallel.
- Upstream fields are not synchronous to clk, so the block only converts after two consecutive identical samples.
- In set mode the hour and minute digits blink.

Parameters:
BLINK_DIV, 25_000_000, clk cycles per blink half-period (0.5 s at 50 MHz); legal range 2..2^26-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sec  input  6  binary seconds, nominally 0..59
min  input  6  binary minutes, nominally 0..59
hr  input  5  binary hours, nominally 0..23
set_mode  input  1  1 = time-set mode (blink HH/MM); asynchronous, 2-flop synchronised internally
HEX0..HEX5  output  7 each  active-low segments, bit0=a..bit6=g; HEX1:HEX0=sec, HEX3:HEX2=min, HEX5:HEX4=hr (tens digit on the higher index)
update_done  output  1  one-cycle pulse when new digits are committed

Behaviour:
- Reset (rst=1 at posedge): HEX0..5 = 7'h7F (blank); update_done = 0; state = IDLE; sample register = 0.
  - Committed-value register resets to sec=63, min=63, hr=31, so the first IDLE cycle converts 00:00:00.
  - Blink counter and phase reset to 0; sync flops reset to 0.
- Reset wins over everything. Reset mid-conversion aborts the conversion with no partial HEX update.
- Sampling: in every state, smp <= {hr,min,sec} each cycle.
- IDLE → LOAD when {hr,min,sec} == smp (stable for 2 samples) and smp != committed.
- LOAD (1 cycle): each field's bin shift register <= smp field (hr zero-extended to 6 bits); BCD regs <= 0; bit counter <= 0. Go to SHIFT.
- SHIFT (exactly 6 cycles): per field, add 3 to each BCD nibble ≥5, then shift {bcd,bin} left by 1. After the 6th shift go to COMMIT.
- COMMIT (1 cycle): segment-encode the BCD digits into HEX registers, committed <= loaded value, update_done = 1 during the following cycle. Go to IDLE.
- Latency: with inputs changed and held from edge 0, HEX registers hold the new value after edge 10; update_done is high in cycle 10–11.
- Input changes during LOAD/SHIFT/COMMIT do not disturb the conversion. IDLE detects the new value afterwards and reconverts.
- Out-of-range inputs (e.g. sec=62, hr=31) are converted and displayed as-is, maximum "63"; no saturation.
- Segment map (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; BCD 10–15 → 7'h7F.
- Blink, driven by set_mode_s (synchronised):
  - When set_mode_s=0: counter=0, phase=0, no blanking.
  - When set_mode_s=1: counter counts 0..BLINK_DIV-1; at wrap, phase toggles.
  - When phase=1, HEX2..HEX5 outputs are forced to 7'h7F; HEX0/HEX1 are unaffected.
  - Blanking is an output mux after the HEX registers, so it does not touch committed digits.
- set_mode 1→0 restores HH/MM digits on the cycle set_mode_s falls.

Decomposition:
- Package time_display_pkg:
  - state enum {IDLE, LOAD, SHIFT, COMMIT}
  - SEG_BLANK constant
  - seg7 encode function (4-bit BCD → 7-bit active-low)
  - field width constants (SEC_W=6, MIN_W=6, HR_W=5)
- Sub-module bin2bcd6_step: one 6-bit-to-2-digit double-dabble datapath with load/shift controls, outputs tens/ones. Instantiated three times; the FSM stays in time_display.

Test Plan:
- Reset, then sec=0,min=0,hr=0 → HEX all blank during reset; 10 edges after release HEX0..5 = 1000000 (all "0"), one update_done pulse.
- Apply hr=23,min=59,sec=59 held → after 10 edges HEX5..0 = 0100100,0110000,0010010,0010000,0010010,0010000 ("235959"), single update_done.
- Change sec 59→0 at the 4th SHIFT cycle → first commit shows "59"; second commit 10+ cycles later shows "00"; two update_done pulses total.
- Toggle sec between 5 and 6 every cycle → no LOAD entered, HEX unchanged, no update_done; hold at 6 → "06" after 10 edges.
- BLINK_DIV=4, set_mode=1 with "12:34:56" shown → HEX2..5 alternate between digits and 7'h7F every 4 cycles, HEX0/1 steady; set_mode=0 → digits restored, no blanking.
- Assert rst during SHIFT → HEX = 7'h7F, no update_done; after release, full reconversion of the current inputs.
